tile_shifter: RTL

- Compaction stage directly downstream of `summation` in the 2048 game logic.
- Takes the merged board (`summed_matrix`) and the move direction, then slides every non-zero tile toward the move edge, closing the zero gaps that merging leaves.
- Processes one line (row or column) per clock and reports completion with `ready`.
- Also reports whether any tile moved, which the game FSM uses to decide whether to spawn a new tile.

---
 rtl/tile_shifter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tile_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tile_shifter: slides non-zero 2048 tiles toward the move edge, one line   |
// | per clock, and flags whether any tile moved.   Revision: 1.0              |
// +--------------------------------------------------------------------------+
module tile_shifter #(
  parameter int TILE_W = 12,
  parameter int N      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [3:0]                       direction,
  input  logic [N-1:0][N-1:0][TILE_W-1:0]  matrix,
  output logic [N-1:0][N-1:0][TILE_W-1:0]  shifted_matrix,
  output logic                             moved,
  output logic                             ready
);

  typedef logic [N-1:0][TILE_W-1:0]        line_t;
  typedef logic [N-1:0][N-1:0][TILE_W-1:0] board_t;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_L0      = 3'd2;
  localparam logic [2:0] S_L1      = 3'd3;
  localparam logic [2:0] S_L2      = 3'd4;
  localparam logic [2:0] S_L3      = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0] state_q, state_d;
  board_t     work_q, work_d;
  board_t     orig_q, orig_d;
  board_t     shifted_q, shifted_d;
  logic [3:0] dir_q, dir_d;
  logic       valid_q, valid_d;
  logic       cols_q, cols_d;
  logic       high_q, high_d;
  logic       moved_q, moved_d;
  logic       ready_q, ready_d;

  logic [1:0] w_k;
  logic [1:0] w_idx [N];
  line_t      w_line_in;
  line_t      w_line_out;
  board_t     w_work_line;

  // Element 0 of a line is the cell on the move edge; packing fills from 0 up.
  function automatic line_t compact(input line_t in);
    line_t      out;
    logic [2:0] cnt;
    out = '0;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (in[i] != '0) begin
        out[cnt[1:0]] = in[i];
        cnt = cnt + 3'd1;
      end
    end
    return out;
  endfunction

  always_comb begin
    w_k         = 2'(state_q - S_L0);
    w_line_in   = '0;
    w_work_line = work_q;
    for (int i = 0; i < N; i++) begin
      w_idx[i] = high_q ? 2'(N - 1 - i) : 2'(i);
    end
    for (int i = 0; i < N; i++) begin
      w_line_in[i] = cols_q ? work_q[w_idx[i]][w_k] : work_q[w_k][w_idx[i]];
    end
    w_line_out = compact(w_line_in);
    for (int i = 0; i < N; i++) begin
      if (cols_q) w_work_line[w_idx[i]][w_k] = w_line_out[i];
      else        w_work_line[w_k][w_idx[i]] = w_line_out[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    orig_d    = orig_q;
    shifted_d = shifted_q;
    dir_d     = dir_q;
    valid_d   = valid_q;
    cols_d    = cols_q;
    high_d    = high_q;
    moved_d   = moved_q;
    ready_d   = ready_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          work_d  = matrix;
          orig_d  = matrix;
          dir_d   = direction;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        valid_d = (dir_q != 4'd0) && ((dir_q & (dir_q - 4'd1)) == 4'd0);
        cols_d  = dir_q[3] | dir_q[2];
        high_d  = dir_q[3] | dir_q[1];
        state_d = S_L0;
      end
      S_L0, S_L1, S_L2: begin
        if (valid_q) work_d = w_work_line;
        state_d = state_q + 3'd1;
      end
      S_L3: begin
        if (valid_q) work_d = w_work_line;
        shifted_d = work_d;
        moved_d   = (work_d != orig_q);
        ready_d   = 1'b1;
        state_d   = S_DONE;
      end
      S_DONE: begin
        if (!enable) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      orig_q    <= '0;
      shifted_q <= '0;
      dir_q     <= '0;
      valid_q   <= 1'b0;
      cols_q    <= 1'b0;
      high_q    <= 1'b0;
      moved_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      orig_q    <= orig_d;
      shifted_q <= shifted_d;
      dir_q     <= dir_d;
      valid_q   <= valid_d;
      cols_q    <= cols_d;
      high_q    <= high_d;
      moved_q   <= moved_d;
      ready_q   <= ready_d;
    end
  end

  assign shifted_matrix = shifted_q;
  assign moved          = moved_q;
  assign ready          = ready_q;

endmodule
`default_nettype wire
